// File: rtl/wb_periph_arb_pkg.sv
// Shared encodings and the arbitration function for the two-master peripheral bus arbiter.
// Grant values are one-hot {m1,m0}; state values match the documented encoding.
package wb_periph_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GNT0 = 2'd1;
    localparam logic [1:0] ST_GNT1 = 2'd2;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    localparam int unsigned TIMEOUT_CYCLES_DEF = 255;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_GNT0 = ST_GNT0,
        S_GNT1 = ST_GNT1
    } arb_state_e;

    // last_gnt = 1 means master 1 held the bus most recently, so master 0 wins a tie.
    function automatic arb_state_e arb(input logic r0, input logic r1, input logic last_gnt);
        arb_state_e nxt;
        nxt = S_IDLE;
        if (r0 && r1) begin
            nxt = last_gnt ? S_GNT0 : S_GNT1;
        end else if (r0) begin
            nxt = S_GNT0;
        end else if (r1) begin
            nxt = S_GNT1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/wb_arb_timeout.sv
// Wait-state watchdog: counts stalled strobe cycles and raises a one-cycle error at the limit.
// After the error the strobe stays blocked until the arbiter changes state.
module wb_arb_timeout
    import wb_periph_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic stall_i,
    input  logic ack_i,
    output logic err_o,
    output logic blk_o
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       blk_q, blk_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= 8'd0;
            blk_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            blk_q <= blk_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        blk_d = blk_q;
        err_o = stall_i && (cnt_q == CNT_LAST);
        if (clr_i || ack_i) begin
            cnt_d = 8'd0;
        end else if (stall_i && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
        if (clr_i) begin
            blk_d = 1'b0;
        end else if (err_o) begin
            blk_d = 1'b1;
        end
    end

    assign blk_o = blk_q;

endmodule

// File: rtl/wb_periph_arbiter.sv
// Two-master Wishbone arbiter (CPU data port = m0, debug/DMA = m1) in front of the peripheral decoder.
// Optional wait-state timeout enabled by defining WB_PERIPH_ARB_TIMEOUT_EN.
module wb_periph_arbiter
    import wb_periph_arb_pkg::*;
#(
    parameter int          AW             = 32,
    parameter int          DW             = 32,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,

    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    input  logic [DW/8-1:0] m0_sel_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,

    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    input  logic [DW/8-1:0] m1_sel_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,

    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    output logic [DW/8-1:0] s_sel_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,

    output logic [1:0]      gnt_o
);

    arb_state_e state_q, state_d;
    logic       last_gnt_q, last_gnt_d;
    logic       sel0, sel1;
    logic       to_err;
    logic       stb_blk;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= S_IDLE;
            last_gnt_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    // A released master is masked out so a waiting master takes over without an idle cycle.
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        case (state_q)
            S_IDLE: state_d = arb(m0_cyc_i, m1_cyc_i, last_gnt_q);
            S_GNT0: if (!m0_cyc_i) state_d = arb(1'b0, m1_cyc_i, last_gnt_q);
            S_GNT1: if (!m1_cyc_i) state_d = arb(m0_cyc_i, 1'b0, last_gnt_q);
            default: state_d = S_IDLE;
        endcase
        if ((state_d == S_GNT0) && (state_q != S_GNT0)) begin
            last_gnt_d = 1'b0;
        end else if ((state_d == S_GNT1) && (state_q != S_GNT1)) begin
            last_gnt_d = 1'b1;
        end
    end

    // Reset overrides the registered grant so every output is quiet while reset is held.
    assign sel0  = (state_q == S_GNT0) && !wb_rst_i;
    assign sel1  = (state_q == S_GNT1) && !wb_rst_i;
    assign gnt_o = sel1 ? GNT_M1 : (sel0 ? GNT_M0 : GNT_NONE);

    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        if (sel0) begin
            s_cyc_o = m0_cyc_i;
            s_stb_o = m0_stb_i && !stb_blk;
            s_we_o  = m0_we_i;
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_sel_o = m0_sel_i;
        end else if (sel1) begin
            s_cyc_o = m1_cyc_i;
            s_stb_o = m1_stb_i && !stb_blk;
            s_we_o  = m1_we_i;
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_sel_o = m1_sel_i;
        end
    end

    assign m0_ack_o = s_ack_i && sel0 && m0_stb_i;
    assign m1_ack_o = s_ack_i && sel1 && m1_stb_i;
    assign m0_dat_o = sel0 ? s_dat_i : '0;
    assign m1_dat_o = sel1 ? s_dat_i : '0;
    assign m0_err_o = sel0 && to_err;
    assign m1_err_o = sel1 && to_err;

`ifdef WB_PERIPH_ARB_TIMEOUT_EN
    wb_arb_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .clr_i   (state_d != state_q),
        .stall_i (s_stb_o && !s_ack_i),
        .ack_i   (s_ack_i),
        .err_o   (to_err),
        .blk_o   (stb_blk)
    );
`else
    assign to_err  = 1'b0;
    assign stb_blk = 1'b0;
`endif

endmodule
